// File: rtl/seg7_pkg.sv
// Shared segment encoding for the hex display bank: active-low patterns, bit6=g .. bit0=a.
// Pure constants and a decode function; no state, no latency.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Index 15 is the leftmost element.
    localparam seg_t [15:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Single-digit hex to seven-segment decoder with a forced-blank override.
// Combinational, zero latency; no flow control.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output seg_t       seg
);

    assign seg = blank ? SEG_BLANK : hex_to_seg(hex);

endmodule

// File: rtl/seg7_display_bank.sv
// N-digit hex display driver: latched value, leading-zero blanking, blink, static and scanned outputs.
// Load takes effect on the following cycle; load is accepted every cycle, no back-pressure.
module seg7_display_bank
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                      ck,
    input  logic                      reset_l,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      blank_lz,
    input  logic                      blink_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output seg_t [NUM_DIGITS-1:0]     hex_static,
    output seg_t                      scan_seg,
    output logic [NUM_DIGITS-1:0]     scan_sel,
    output logic [4*NUM_DIGITS-1:0]   shown_value,
    output logic                      blink_phase
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [BW-1:0]           blink_cnt;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           scan_idx;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    lz_run;

    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= value;
        end
    end

    // A load restarts the visible half-period so fresh data is never shown blanked.
    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (load) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Walk from the MS digit down; the run of zeros ends at the first nonzero digit.
    always_comb begin
        lz_blank = '0;
        lz_run   = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run & (value_q[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_run;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_to_seg7 u_dec (
            .hex   (value_q[4*g +: 4]),
            .blank (lz_blank[g] | (blink_en & blink_mask[g] & blink_phase)),
            .seg   (hex_static[g])
        );
    end

    assign scan_sel    = NUM_DIGITS'(1) << scan_idx;
    assign scan_seg    = hex_static[scan_idx];
    assign shown_value = value_q;

endmodule

// File: tb/tb_seg7_display_bank.sv
// Directed and random checks of seg7_display_bank against an arithmetic reference model.
module tb_seg7_display_bank;

    localparam int N  = 4;
    localparam int BD = 4;
    localparam int SD = 2;
    localparam int SCAN_PERIOD = SD * N;

    logic              ck = 1'b0;
    logic              reset_l;
    logic              load;
    logic [4*N-1:0]    value;
    logic              blank_lz;
    logic              blink_en;
    logic [N-1:0]      blink_mask;
    logic [N-1:0][6:0] hex_static;
    logic [6:0]        scan_seg;
    logic [N-1:0]      scan_sel;
    logic [4*N-1:0]    shown_value;
    logic              blink_phase;

    int n_cmp = 0;
    int n_err = 0;

    logic [4*N-1:0] m_val;
    int             m_bcnt;
    int             m_scnt;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 ck = ~ck;

    seg7_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(BD), .SCAN_DIV(SD)) dut (
        .ck          (ck),
        .reset_l     (reset_l),
        .load        (load),
        .value       (value),
        .blank_lz    (blank_lz),
        .blink_en    (blink_en),
        .blink_mask  (blink_mask),
        .hex_static  (hex_static),
        .scan_seg    (scan_seg),
        .scan_sel    (scan_sel),
        .shown_value (shown_value),
        .blink_phase (blink_phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val  = '0;
        m_bcnt = 0;
        m_scnt = 0;
    endtask

    function automatic logic m_phase();
        return ((m_bcnt / BD) % 2) == 1;
    endfunction

    function automatic int m_idx();
        return (m_scnt / SD) % N;
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        logic [3:0] d;
        d = 4'((m_val >> (4*i)) & 16'hF);
        if ((blank_lz && i > 0 && (m_val >> (4*i)) == 0) ||
            (blink_en && blink_mask[i] && m_phase()))
            return 7'h7F;
        return tbl[d];
    endfunction

    task automatic check_all();
        for (int i = 0; i < N; i++)
            chk($sformatf("hex_static[%0d]", i), 32'(hex_static[i]), 32'(exp_seg(i)));
        chk("scan_sel", 32'(scan_sel), 32'(1 << m_idx()));
        chk("scan_seg", 32'(scan_seg), 32'(exp_seg(m_idx())));
        chk("shown_value", 32'(shown_value), 32'(m_val));
        chk("blink_phase", 32'(blink_phase), 32'(m_phase()));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge ck);
        if (!reset_l) begin
            model_reset();
        end else begin
            if (load) begin
                m_val  = value;
                m_bcnt = 0;
            end else begin
                m_bcnt++;
            end
            m_scnt++;
        end
        @(negedge ck);
        check_all();
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        logic reached;
        reset_l    = 1'b1;
        load       = 1'b0;
        value      = '0;
        blank_lz   = 1'b0;
        blink_en   = 1'b0;
        blink_mask = '0;
        model_reset();

        // Reset state, with and without leading-zero blanking
        #1 reset_l = 1'b0;
        #1 check_all();
        blank_lz = 1'b1;
        #1 check_all();
        blank_lz = 1'b0;
        step();
        reset_l = 1'b1;

        // Plain decode
        do_load(16'h1A3F);
        step();

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0050);
        do_load(16'h0000);
        do_load(16'h1000);
        do_load(16'h0001);
        blank_lz = 1'b0;

        // Blink on digit 0, then a load during the blanked half
        blink_en   = 1'b1;
        blink_mask = 4'b0001;
        do_load(16'h1234);
        for (int k = 0; k < 12; k++) step();
        reached = m_phase();
        for (int k = 0; k < 2*BD && !reached; k++) begin
            step();
            reached = m_phase();
        end
        chk("wait_blank_half", 32'(reached), 32'd1);
        do_load(16'h5678);
        for (int k = 0; k < BD + 2; k++) step();

        // Line up scan index 2 with the blanked half, then reset between edges
        blink_mask = 4'b1111;
        reached = 1'b0;
        for (int k = 0; k < SCAN_PERIOD && !reached; k++) begin
            step();
            reached = (m_scnt % SCAN_PERIOD) == SCAN_PERIOD - 1;
        end
        chk("wait_scan_align", 32'(reached), 32'd1);
        do_load(16'h9ABC);
        for (int k = 0; k < BD; k++) step();
        chk("pre_reset_idx", 32'(scan_sel), 32'b0100);
        chk("pre_reset_phase", 32'(blink_phase), 32'd1);
        @(posedge ck);
        m_bcnt++;
        m_scnt++;
        #3 reset_l = 1'b0;
        model_reset();
        #1;
        chk("async_scan_sel", 32'(scan_sel), 32'b0001);
        chk("async_blink_phase", 32'(blink_phase), 32'd0);
        chk("async_shown_value", 32'(shown_value), 32'd0);
        check_all();
        @(negedge ck);
        step();
        reset_l = 1'b1;
        blink_en = 1'b0;

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            load       = ($urandom_range(0, 3) == 0);
            value      = 16'($urandom);
            if ($urandom_range(0, 1) == 0) value = value & 16'h00FF;
            blank_lz   = 1'($urandom);
            blink_en   = 1'($urandom);
            blink_mask = 4'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
